// File: rtl/peripheral_counter_fifo_core.sv
// Device-side register core: 32-bit up/down counter with wrap interrupt, config bits,
// and an 8-bit first-word-fall-through FIFO behind the native register interface.
module peripheral_counter_fifo_core #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned LT_THRESHOLD = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        config_we,
  input  logic        fifo_we,
  input  logic        fifo_re,
  input  logic [31:0] count_in,
  input  logic        en_in,
  input  logic        dir_in,
  input  logic        ire_in,
  input  logic [7:0]  fifo_data_in,
  output logic [31:0] count_out,
  output logic        en_out,
  output logic        dir_out,
  output logic        ire_out,
  output logic        lt_1k_out,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic [7:0]  fifo_word_count,
  output logic [7:0]  fifo_data_out,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]   count_q;
  logic          en_q;
  logic          dir_q;
  logic          ire_q;
  logic          irq_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    word_count;

  logic          fifo_is_empty;
  logic          fifo_is_full;
  logic          do_push;
  logic          do_pop;
  logic          step_wraps;

  always_comb begin
    fifo_is_empty = (word_count == '0);
    fifo_is_full  = (word_count == 8'(FIFO_DEPTH));
    do_pop        = fifo_re && !fifo_is_empty;
    // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
    do_push       = fifo_we && (!fifo_is_full || do_pop);
    step_wraps    = ire_q && (dir_q ? (count_q == '0) : (count_q == '1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      en_q    <= 1'b0;
      dir_q   <= 1'b0;
      ire_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (count_we) begin
        count_q <= count_in;
      end else if (en_q) begin
        count_q <= dir_q ? (count_q - 32'd1) : (count_q + 32'd1);
        irq_q   <= step_wraps;
      end
      if (config_we) begin
        en_q  <= en_in;
        dir_q <= dir_in;
        ire_q <= ire_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   word_count <= word_count + 8'd1;
        2'b01:   word_count <= word_count - 8'd1;
        default: word_count <= word_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= fifo_data_in;
  end

  assign count_out       = count_q;
  assign en_out          = en_q;
  assign dir_out         = dir_q;
  assign ire_out         = ire_q;
  assign lt_1k_out       = (count_q < LT_THRESHOLD);
  assign irq             = irq_q;
  assign fifo_empty      = fifo_is_empty;
  assign fifo_full       = fifo_is_full;
  assign fifo_word_count = word_count;
  assign fifo_data_out   = fifo_is_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_peripheral_counter_fifo_core.sv
// Bench for peripheral_counter_fifo_core: directed scenarios plus randomized traffic,
// all checked against a queue-based behavioural model kept here.
module tb_peripheral_counter_fifo_core;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LT    = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        count_we = 1'b0, config_we = 1'b0, fifo_we = 1'b0, fifo_re = 1'b0;
  logic [31:0] count_in = '0;
  logic        en_in = 1'b0, dir_in = 1'b0, ire_in = 1'b0;
  logic [7:0]  fifo_data_in = '0;
  logic [31:0] count_out;
  logic        en_out, dir_out, ire_out, lt_1k_out, fifo_empty, fifo_full, irq;
  logic [7:0]  fifo_word_count, fifo_data_out;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_count = '0;
  logic        m_en = 1'b0, m_dir = 1'b0, m_ire = 1'b0, m_irq = 1'b0;
  logic [7:0]  m_q[$];

  peripheral_counter_fifo_core #(.FIFO_DEPTH(DEPTH), .LT_THRESHOLD(LT)) dut (
    .clk(clk), .reset(reset), .count_we(count_we), .config_we(config_we),
    .fifo_we(fifo_we), .fifo_re(fifo_re), .count_in(count_in), .en_in(en_in),
    .dir_in(dir_in), .ire_in(ire_in), .fifo_data_in(fifo_data_in),
    .count_out(count_out), .en_out(en_out), .dir_out(dir_out), .ire_out(ire_out),
    .lt_1k_out(lt_1k_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_word_count(fifo_word_count), .fifo_data_out(fifo_data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_head();
    return (m_q.size() == 0) ? 8'h00 : m_q[0];
  endfunction

  // Advances model and DUT by one clock; strobes are one-shot and cleared afterwards.
  task automatic tick();
    logic [31:0] n_count;
    logic        n_en, n_dir, n_ire, n_irq;
    logic        pop;
    n_count = m_count; n_en = m_en; n_dir = m_dir; n_ire = m_ire; n_irq = 1'b0;
    if (reset) begin
      n_count = 0; n_en = 0; n_dir = 0; n_ire = 0;
      m_q.delete();
    end else begin
      if (count_we) n_count = count_in;
      else if (m_en) begin
        if (!m_dir) begin
          n_irq   = m_ire && (m_count == 32'hFFFF_FFFF);
          n_count = m_count + 1;
        end else begin
          n_irq   = m_ire && (m_count == 0);
          n_count = m_count - 1;
        end
      end
      if (config_we) begin n_en = en_in; n_dir = dir_in; n_ire = ire_in; end
      pop = fifo_re && (m_q.size() > 0);
      if (pop) void'(m_q.pop_front());
      if (fifo_we && (m_q.size() < DEPTH)) m_q.push_back(fifo_data_in);
    end
    @(posedge clk);
    #1;
    m_count = n_count; m_en = n_en; m_dir = n_dir; m_ire = n_ire; m_irq = n_irq;
    reset = 0; count_we = 0; config_we = 0; fifo_we = 0; fifo_re = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (count_out !== 32'd0 || en_out !== 1'b0 || dir_out !== 1'b0 || ire_out !== 1'b0 ||
          irq !== 1'b0) begin
        failures++;
        $display("FAIL reset_ctr: count=%h en=%b dir=%b ire=%b irq=%b, required all zero",
                 count_out, en_out, dir_out, ire_out, irq);
      end
      checks++;
      if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_word_count !== 8'd0 ||
          fifo_data_out !== 8'h00 || lt_1k_out !== 1'b1) begin
        failures++;
        $display("FAIL reset_fifo: empty=%b full=%b wc=%0d dout=%h lt=%b, required 1 0 0 00 1",
                 fifo_empty, fifo_full, fifo_word_count, fifo_data_out, lt_1k_out);
      end
      tick();
    end
  endtask

  task automatic test_lt_threshold();
    logic exp_lt[3] = '{1'b1, 1'b1, 1'b0};
    count_we = 1; count_in = 32'd998;
    config_we = 1; en_in = 1; dir_in = 0; ire_in = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (count_out !== 32'(998 + i) || lt_1k_out !== exp_lt[i]) begin
        failures++;
        $display("FAIL lt_threshold: count=%0d lt=%b, required count=%0d lt=%b",
                 count_out, lt_1k_out, 998 + i, exp_lt[i]);
      end
      tick();
    end
  endtask

  task automatic test_wrap_up(input logic ire);
    logic [31:0] exp_c[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    logic        exp_i[4];
    exp_i = '{1'b0, 1'b0, ire, 1'b0};
    count_we = 1; count_in = 32'hFFFF_FFFE;
    config_we = 1; en_in = 1; dir_in = 0; ire_in = ire;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (count_out !== exp_c[i] || irq !== exp_i[i] || irq !== m_irq) begin
        failures++;
        $display("FAIL wrap_up ire=%b step%0d: count=%h irq=%b, required count=%h irq=%b",
                 ire, i, count_out, irq, exp_c[i], exp_i[i]);
      end
      tick();
    end
  endtask

  task automatic test_wrap_down();
    logic [31:0] exp_c[4] = '{32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic        exp_i[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    count_we = 1; count_in = 32'h1;
    config_we = 1; en_in = 1; dir_in = 1; ire_in = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (count_out !== exp_c[i] || irq !== exp_i[i]) begin
        failures++;
        $display("FAIL wrap_down step%0d: count=%h irq=%b, required count=%h irq=%b",
                 i, count_out, irq, exp_c[i], exp_i[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_priority();
    // Counter is running down with ire=1; a load must win over the step.
    count_we = 1; count_in = 32'h1234_5678; tick();
    checks++;
    if (count_out !== 32'h1234_5678) begin
      failures++;
      $display("FAIL load_priority: count=%h, required 12345678", count_out);
    end
    // Wrap through a load never interrupts.
    config_we = 1; en_in = 1; dir_in = 0; ire_in = 1;
    count_we = 1; count_in = 32'hFFFF_FFFF; tick();
    count_we = 1; count_in = 32'h0; tick();
    checks++;
    if (count_out !== 32'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL load_no_irq: count=%h irq=%b, required 0 0", count_out, irq);
    end
    // Config write in the same cycle as a step: the step uses the old direction.
    config_we = 1; en_in = 1; dir_in = 1; ire_in = 0; tick();
    checks++;
    if (count_out !== 32'h1 || dir_out !== 1'b1) begin
      failures++;
      $display("FAIL config_old_dir: count=%h dir=%b, required 1 1", count_out, dir_out);
    end
    tick();
    checks++;
    if (count_out !== 32'h0) begin
      failures++;
      $display("FAIL config_new_dir: count=%h, required 0", count_out);
    end
    config_we = 1; en_in = 0; dir_in = 0; ire_in = 0; tick();
  endtask

  task automatic test_fifo_fill_drain();
    for (int i = 0; i < 16; i++) begin
      fifo_we = 1; fifo_data_in = 8'(8'h10 + i); tick();
      checks++;
      if (fifo_word_count !== 8'(i + 1) || fifo_empty !== 1'b0 || fifo_data_out !== 8'h10) begin
        failures++;
        $display("FAIL fill%0d: wc=%0d empty=%b dout=%h, required wc=%0d empty=0 dout=10",
                 i, fifo_word_count, fifo_empty, fifo_data_out, i + 1);
      end
    end
    fifo_we = 1; fifo_data_in = 8'hAA; tick();
    checks++;
    if (fifo_full !== 1'b1 || fifo_word_count !== 8'd16 || fifo_data_out !== 8'h10) begin
      failures++;
      $display("FAIL full_drop: full=%b wc=%0d dout=%h, required 1 16 10",
               fifo_full, fifo_word_count, fifo_data_out);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (fifo_data_out !== 8'(8'h10 + i)) begin
        failures++;
        $display("FAIL drain%0d: dout=%h, required %h", i, fifo_data_out, 8'(8'h10 + i));
      end
      fifo_re = 1; tick();
    end
    checks++;
    if (fifo_empty !== 1'b1 || fifo_word_count !== 8'd0 || fifo_data_out !== 8'h00) begin
      failures++;
      $display("FAIL drained: empty=%b wc=%0d dout=%h, required 1 0 00",
               fifo_empty, fifo_word_count, fifo_data_out);
    end
    fifo_re = 1; tick();
    checks++;
    if (fifo_word_count !== 8'd0 || fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL pop_empty: wc=%0d empty=%b, required 0 1", fifo_word_count, fifo_empty);
    end
  endtask

  task automatic test_fifo_simul();
    fifo_we = 1; fifo_re = 1; fifo_data_in = 8'h5A; tick();
    checks++;
    if (fifo_word_count !== 8'd1 || fifo_data_out !== 8'h5A) begin
      failures++;
      $display("FAIL simul_empty: wc=%0d dout=%h, required 1 5A", fifo_word_count, fifo_data_out);
    end
    for (int i = 0; i < 15; i++) begin
      fifo_we = 1; fifo_data_in = 8'(8'h60 + i); tick();
    end
    fifo_we = 1; fifo_re = 1; fifo_data_in = 8'hC3; tick();
    checks++;
    if (fifo_word_count !== 8'd16 || fifo_full !== 1'b1 || fifo_data_out !== 8'h60) begin
      failures++;
      $display("FAIL simul_full: wc=%0d full=%b dout=%h, required 16 1 60",
               fifo_word_count, fifo_full, fifo_data_out);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (fifo_data_out !== m_head()) begin
        failures++;
        $display("FAIL simul_drain%0d: dout=%h, required %h", i, fifo_data_out, m_head());
      end
      fifo_re = 1; tick();
    end
    checks++;
    if (fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL simul_drained: empty=%b, required 1", fifo_empty);
    end
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 5; i++) begin
      fifo_we = 1; fifo_data_in = 8'(i + 1); tick();
    end
    count_we = 1; count_in = 32'd5000; tick();
    reset = 1; fifo_we = 1; count_we = 1; tick();
    checks++;
    if (fifo_word_count !== 8'd0 || fifo_empty !== 1'b1 || count_out !== 32'd0 ||
        fifo_data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_fill: wc=%0d empty=%b count=%0d dout=%h, required 0 1 0 00",
               fifo_word_count, fifo_empty, count_out, fifo_data_out);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      count_we  = ($urandom_range(0, 19) == 0);
      config_we = ($urandom_range(0, 9) == 0);
      fifo_we   = $urandom_range(0, 1);
      fifo_re   = $urandom_range(0, 1);
      en_in     = ($urandom_range(0, 3) != 0);
      dir_in    = $urandom_range(0, 1);
      ire_in    = $urandom_range(0, 1);
      fifo_data_in = 8'($urandom);
      case ($urandom_range(0, 4))
        0: count_in = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        1: count_in = 32'($urandom_range(0, 3));
        2: count_in = 32'($urandom_range(LT - 3, LT + 3));
        default: count_in = $urandom;
      endcase
      tick();
      checks++;
      if (count_out !== m_count || en_out !== m_en || dir_out !== m_dir ||
          ire_out !== m_ire || irq !== m_irq || lt_1k_out !== (m_count < LT)) begin
        failures++;
        $display("FAIL rand_ctr%0d: count=%h en=%b dir=%b ire=%b irq=%b lt=%b, required %h %b %b %b %b %b",
                 n, count_out, en_out, dir_out, ire_out, irq, lt_1k_out,
                 m_count, m_en, m_dir, m_ire, m_irq, (m_count < LT));
      end
      checks++;
      if (fifo_word_count !== 8'(m_q.size()) || fifo_empty !== (m_q.size() == 0) ||
          fifo_full !== (m_q.size() == DEPTH) || fifo_data_out !== m_head()) begin
        failures++;
        $display("FAIL rand_fifo%0d: wc=%0d empty=%b full=%b dout=%h, required %0d %b %b %h",
                 n, fifo_word_count, fifo_empty, fifo_full, fifo_data_out,
                 m_q.size(), (m_q.size() == 0), (m_q.size() == DEPTH), m_head());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lt_threshold();
    test_wrap_up(1'b1);
    test_wrap_up(1'b0);
    test_wrap_down();
    test_load_priority();
    test_fifo_fill_drain();
    test_fifo_simul();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
